// File: rtl/planificador_mdio_pkg.sv
// -----------------------------------------------------------------------------
// planificador_mdio_pkg
// Shared definitions for the MDIO round-robin scheduler:
//   - FSM state encoding (IDLE, START, BUSY, DONE)
//   - Clause-22 OP codes (OP_READ, OP_WRITE)
//   - Bit positions of the fields inside a 32-bit transaction word
//   - es_lectura(): true when a transaction word encodes a read
// -----------------------------------------------------------------------------
package planificador_mdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } estado_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Transaction word layout: ST | OP | PHY | REG | TA | DATA
  localparam int ST_MSB   = 31;
  localparam int ST_LSB   = 30;
  localparam int OP_MSB   = 29;
  localparam int OP_LSB   = 28;
  localparam int PHY_MSB  = 27;
  localparam int PHY_LSB  = 23;
  localparam int REG_MSB  = 22;
  localparam int REG_LSB  = 18;
  localparam int TA_MSB   = 17;
  localparam int TA_LSB   = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  function automatic logic es_lectura(input logic [31:0] palabra);
    return palabra[OP_MSB:OP_LSB] == OP_READ;
  endfunction

endpackage

// File: rtl/planificador_mdio_arbitro_rr.sv
// -----------------------------------------------------------------------------
// arbitro_rr
// Purely combinational round-robin next-grant logic. Searches req_valid
// starting at ptr+1 with wrap-around and reports the first set bit.
// The pointer register itself lives in the scheduler FSM.
// Ports:
//   req_valid  in  N_REQ  pending requests
//   ptr        in  IDX_W  index of the last granted requester
//   grant      out N_REQ  one-hot grant (all zero when nothing pending)
//   grant_idx  out IDX_W  index of the granted requester
//   grant_any  out 1      at least one request pending
// -----------------------------------------------------------------------------
module arbitro_rr #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    // Offsets 1..N_REQ visit every requester once, the current owner last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/planificador_mdio.sv
// -----------------------------------------------------------------------------
// planificador_mdio
// Round-robin scheduler sharing one generador_mdio master among N_REQ
// requesters. Latches a Clause-22 word, pulses start_stb, counts mdc rising
// edges to detect end of frame, captures the last 16 mdio_in bits as read
// data and returns a per-requester done pulse.
// Optional feature macro: PLANIFICADOR_MDIO_TIMEOUT_EN
//   defined   -> watchdog aborts a frame after TIMEOUT_CYC cycles with no
//                mdc rising edge (done + err, no rd_valid)
//   undefined -> no watchdog, err tied to 0
// Ports:
//   clk, reset (async, active-low)
//   req_valid[N_REQ], req_trans[32*N_REQ]  request side inputs
//   req_ack[N_REQ], done[N_REQ]            per-requester pulses
//   rd_data[16], rd_valid, err, busy       completion / status
//   transaccion[32], start_stb             to generador_mdio
//   mdc, mdio_in                           from generador_mdio / PHY
// -----------------------------------------------------------------------------
module planificador_mdio
  import planificador_mdio_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int MDC_BITS    = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_trans,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     done,
  output logic [15:0]          rd_data,
  output logic                 rd_valid,
  output logic                 err,
  output logic                 busy,
  output logic [31:0]          transaccion,
  output logic                 start_stb,
  input  logic                 mdc,
  input  logic                 mdio_in
);

  localparam int IDX_W = (N_REQ > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(MDC_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(MDC_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_RD_FIRST = CNT_W'(MDC_BITS - 16);

  estado_e            estado_q, estado_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [31:0]        trans_q, trans_d;
  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               mdc_q, mdc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        rd_shift_q, rd_shift_d;

  logic [N_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [31:0]        gnt_word;
  logic               mdc_rise;

`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               to_q, to_d;
  logic               err_q, err_d;
`else
  logic               unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  arbitro_rr #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arbitro (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (gnt_oh),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // Word of the winning requester, selected with constant slices.
  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) gnt_word = req_trans[32*i +: 32];
    end
  end

  assign mdc_rise = mdc & ~mdc_q;

  always_comb begin
    estado_d   = estado_q;
    ptr_d      = ptr_q;
    trans_d    = trans_q;
    req_ack_d  = '0;
    done_d     = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    start_d    = 1'b0;
    mdc_d      = mdc;
    cnt_d      = cnt_q;
    rd_shift_d = rd_shift_q;
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
    wd_d       = wd_q;
    to_d       = to_q;
    err_d      = 1'b0;
`endif

    unique case (estado_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (gnt_any) begin
          ptr_d     = gnt_idx;
          trans_d   = gnt_word;
          req_ack_d = gnt_oh;
          busy_d    = 1'b1;
          estado_d  = ST_START;
        end
      end

      ST_START: begin
        start_d  = 1'b1;
        cnt_d    = '0;
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
        wd_d     = '0;
        to_d     = 1'b0;
`endif
        estado_d = ST_BUSY;
      end

      ST_BUSY: begin
        if (mdc_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Data phase is the last 16 edges of the frame, MSB first.
          if (cnt_q >= CNT_RD_FIRST) rd_shift_d = {rd_shift_q[14:0], mdio_in};
          if (cnt_q == CNT_LAST) estado_d = ST_DONE;
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          to_d     = 1'b1;
          estado_d = ST_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end

      ST_DONE: begin
        done_d[ptr_q] = 1'b1;
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
        err_d = to_q;
        if (!to_q && es_lectura(trans_q)) begin
`else
        if (es_lectura(trans_q)) begin
`endif
          rd_valid_d = 1'b1;
          rd_data_d  = rd_shift_q;
        end
        estado_d = ST_IDLE;
      end

      default: estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= ST_IDLE;
      ptr_q      <= IDX_W'(N_REQ - 1);
      trans_q    <= '0;
      req_ack_q  <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      mdc_q      <= 1'b0;
      cnt_q      <= '0;
      rd_shift_q <= '0;
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
      wd_q       <= '0;
      to_q       <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      ptr_q      <= ptr_d;
      trans_q    <= trans_d;
      req_ack_q  <= req_ack_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      mdc_q      <= mdc_d;
      cnt_q      <= cnt_d;
      rd_shift_q <= rd_shift_d;
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
      wd_q       <= wd_d;
      to_q       <= to_d;
      err_q      <= err_d;
`endif
    end
  end

  assign req_ack     = req_ack_q;
  assign done        = done_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign transaccion = trans_q;
  assign start_stb   = start_q;
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_planificador_mdio.sv
// -----------------------------------------------------------------------------
// tb_planificador_mdio
// Self-checking bench for planificador_mdio. A small generator model answers
// start_stb with MDC_BITS mdc pulses and drives mdio_in; a transaction-level
// reference model predicts grants, pulses and read data every cycle.
// -----------------------------------------------------------------------------
module tb_planificador_mdio;

  localparam int N    = 2;
  localparam int BITS = 32;
  localparam int TO   = 64;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [32*N-1:0]    req_trans;
  logic [N-1:0]       req_ack;
  logic [N-1:0]       done;
  logic [15:0]        rd_data;
  logic               rd_valid;
  logic               err;
  logic               busy;
  logic [31:0]        transaccion;
  logic               start_stb;
  logic               mdc;
  logic               mdio_in;

  planificador_mdio #(
    .N_REQ       (N),
    .MDC_BITS    (BITS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid   (req_valid),
    .req_trans   (req_trans),
    .req_ack     (req_ack),
    .done        (done),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .err         (err),
    .busy        (busy),
    .transaccion (transaccion),
    .start_stb   (start_stb),
    .mdc         (mdc),
    .mdio_in     (mdio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- shared model state ----------------
  logic [15:0]  rsp_tab [N];     // read data the PHY returns per requester
  bit           gen_freeze = 0;  // generator ignores start_stb (mdc stuck)
  int           gen_edge = 0;
  int           gen_done_exp = -1;

  bit           m_active = 0;
  int           m_ptr = N - 1;
  int           m_g = 0;
  logic [31:0]  m_word = '0;
  logic [15:0]  m_rd = '0;
  logic [N-1:0] exp_ack = '0;
  int           exp_idx = -1;
  bit           exp_start = 0;
  int           m_to_cyc = -1;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- generator / PHY model ----------------
  task automatic run_frame();
    bit ok;
    logic [15:0] rsp;
    ok = 1;
    gen_edge = 0;
    gen_done_exp = -1;
    rsp = rsp_tab[m_g];
    for (int e = 1; e <= BITS && ok; e++) begin
      mdio_in = (e > BITS - 16) ? rsp[BITS - e] : 1'($urandom % 2);
      repeat (2) begin @(posedge clk); #1; if (!rst_n) ok = 0; end
      if (ok) begin
        mdc = 1'b1;
        gen_edge = e;
        if (e == BITS) gen_done_exp = cyc + 2;
        repeat (2) begin @(posedge clk); #1; if (!rst_n) ok = 0; end
        mdc = 1'b0;
      end
    end
    mdc = 1'b0;
    if (!ok) gen_done_exp = -1;
  endtask

  initial begin
    mdc = 1'b0;
    mdio_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && start_stb && !gen_freeze) run_frame();
    end
  end

  // Requesters drop their request once acknowledged.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (req_ack[i]) req_valid[i] = 1'b0;
  end

  // ---------------- per-cycle reference compare ----------------
  always @(negedge clk) begin : cmp
    logic [N-1:0] exp_done_v;
    bit dn, to, rd;
    if (!rst_n) begin
      chk("rst_ack", 32'(req_ack), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(start_stb), 0);
      chk("rst_rdv", 32'(rd_valid), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rddata", 32'(rd_data), 0);
      chk("rst_trans", transaccion, 0);
      m_active = 0; m_ptr = N - 1; m_word = '0; m_rd = '0;
      exp_ack = '0; exp_idx = -1; exp_start = 0; m_to_cyc = -1;
    end else begin
      if (exp_ack != '0) begin
        m_g = exp_idx;
        m_ptr = exp_idx;
        m_word = req_trans[32*exp_idx +: 32];
        m_active = 1;
      end
      dn = m_active && (exp_ack == '0) && (cyc == gen_done_exp || cyc == m_to_cyc);
      to = dn && (cyc == m_to_cyc);
      exp_done_v = '0;
      if (dn) exp_done_v[m_g] = 1'b1;
      rd = dn && !to && (m_word[29:28] == 2'b10);
      if (rd) m_rd = rsp_tab[m_g];

      chk("req_ack", 32'(req_ack), 32'(exp_ack));
      chk("start_stb", 32'(start_stb), 32'(exp_start));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(exp_done_v));
      chk("rd_valid", 32'(rd_valid), 32'(rd));
      chk("err", 32'(err), 32'(to));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
      chk("transaccion", transaccion, m_word);

`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
      if (exp_start && gen_freeze) m_to_cyc = cyc + TO + 1;
`endif
      if (dn) begin m_active = 0; m_to_cyc = -1; end
      exp_start = (exp_ack != '0);
      exp_ack = '0;
      exp_idx = -1;
      if (!m_active) begin
        exp_idx = rr_pick(req_valid, m_ptr);
        if (exp_idx >= 0) exp_ack[exp_idx] = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int          order [$];
  logic        last_rdv, last_err;
  logic [15:0] last_rd;
  logic [31:0] last_trans;

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic raise(input int i, input logic [31:0] w, input logic [15:0] r);
    req_trans[32*i +: 32] = w;
    rsp_tab[i] = r;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int got, b;
    got = 0; b = 0;
    while (got < n && b < budget) begin
      @(negedge clk);
      b++;
      if (done != '0) begin
        got++;
        for (int i = 0; i < N; i++) if (done[i]) order.push_back(i);
        last_rdv = rd_valid; last_err = err; last_rd = rd_data; last_trans = transaccion;
      end
    end
    chk("dones_seen", 32'(got), 32'(n));
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (ncyc) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b, cnt;
    logic [N-1:0] mask;
    rst_n = 1'b0;
    req_valid = '0;
    req_trans = '0;
    for (int i = 0; i < N; i++) rsp_tab[i] = '0;
    do_reset(3);
    tick();

    // Single write from requester 0
    order.delete();
    raise(0, 32'h5BA73549, 16'h0000);
    wait_dones(1, 400);
    chk("wr_idx", 32'(order[0]), 0);
    chk("wr_rd_valid", 32'(last_rdv), 0);
    chk("wr_trans", last_trans, 32'h5BA73549);
    tick();

    // Single read from requester 1
    order.delete();
    raise(1, 32'h65557777, 16'h2468);
    wait_dones(1, 400);
    chk("rd_idx", 32'(order[0]), 1);
    chk("rd_valid_lit", 32'(last_rdv), 1);
    chk("rd_data_lit", 32'(last_rd), 32'h2468);
    tick();

    // Contention, twice: strict rotation 0,1,0,1
    for (int rep = 0; rep < 2; rep++) begin
      order.delete();
      raise(0, 32'h5000_0000 | 32'($urandom_range(0, 16'hFFFF)), 16'h1111);
      raise(1, 32'h6000_0000 | 32'($urandom_range(0, 16'hFFFF)), 16'h9C3A);
      wait_dones(2, 800);
      chk("rr_first", 32'(order[0]), 0);
      chk("rr_second", 32'(order[1]), 1);
      chk("rr_read_data", 32'(last_rd), 32'h9C3A);
      tick();
    end

    // Random mixes of requesters, OPs and read data
    for (int r = 0; r < 6; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          raise(i, {2'b01, ($urandom % 2) ? 2'b10 : 2'b01, 28'($urandom)}, 16'($urandom));
          cnt++;
        end
      end
      wait_dones(cnt, 400 * cnt);
      repeat (r % 3) tick();
      tick();
    end

    // Reset in the middle of a frame, after the 10th mdc edge
    raise(0, 32'h5A0A1234, 16'h0000);
    b = 0;
    while (gen_edge != 10 && b < 300) begin @(negedge clk); b++; end
    chk("edge10_reached", 32'(gen_edge), 10);
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_trans", transaccion, 0);
    chk("mid_rst_done", 32'(done), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    order.delete();
    raise(1, 32'h6ABCFFFF, 16'hBEEF);
    wait_dones(1, 400);
    chk("post_rst_idx", 32'(order[0]), 1);
    chk("post_rst_rd", 32'(last_rd), 32'hBEEF);
    tick();

    // Generator stuck: mdc never toggles
    gen_freeze = 1;
    order.delete();
    raise(0, 32'h5123ABCD, 16'h0000);
`ifdef PLANIFICADOR_MDIO_TIMEOUT_EN
    wait_dones(1, 300);
    chk("to_err", 32'(last_err), 1);
    chk("to_rd_valid", 32'(last_rdv), 0);
    chk("to_idx", 32'(order[0]), 0);
`else
    repeat (200) tick();
    chk("hang_busy", 32'(busy), 1);
    chk("hang_err", 32'(err), 0);
`endif
    tick();
    do_reset(2);
    gen_freeze = 0;
    tick();

    // Normal operation after recovery
    order.delete();
    raise(0, 32'h6F0F0000, 16'h5A5A);
    wait_dones(1, 400);
    chk("recover_rd", 32'(last_rd), 32'h5A5A);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
